// File: rtl/uop_decode.sv
`default_nettype none
// ============================================================================
// Module      : uop_decode
// Description : Two-wide decode stage with physical destination register
//               allocation from a circular freelist and branch checkpoints.
// Revision    : 1.0
// ============================================================================
module uop_decode #(
  parameter int NUM_PREGS              = 64,
  parameter int MAX_PREDICT_DEPTH_BITS = 2,
  parameter int ARCH_REGS              = 32,
  localparam int PREG_W                = $clog2(NUM_PREGS),
  localparam int TAG_W                 = MAX_PREDICT_DEPTH_BITS,
  localparam int INS_W                 = 32 + TAG_W,
  localparam int DEC_W                 = 33 + TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              prev_valid,
  input  logic              enabled,
  input  logic              next_enabled,
  input  logic              next_stalled,
  output logic              stalled,
  output logic              valid,
  input  logic [INS_W-1:0]  instruction_1,
  input  logic [INS_W-1:0]  instruction_2,
  output logic [DEC_W-1:0]  decoded_1,
  output logic [DEC_W-1:0]  decoded_2,
  output logic [PREG_W-1:0] preg1,
  output logic [PREG_W-1:0] preg2,
  output logic [1:0]        num_execute,
  input  logic              branch_shootdown,
  input  logic [TAG_W-1:0]  shootdown_branch_tag,
  input  logic              free1,
  input  logic              free2,
  input  logic [PREG_W-1:0] free1_addr,
  input  logic [PREG_W-1:0] free2_addr
);

  localparam int FL_DEPTH = NUM_PREGS - ARCH_REGS;
  localparam int FL_IDX   = $clog2(FL_DEPTH);
  localparam int PTR_W    = FL_IDX + 1;
  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int HD_BIT   = TAG_W;
  localparam int BR_BIT   = TAG_W + 29;
  localparam int RS_LO    = BR_BIT + 1;

  // Packed layout: {is_noop, rs_station, is_branch, rd, rs1, rs2, imm, has_dest, branch_tag}
  function automatic logic [DEC_W-1:0] decode(input logic [INS_W-1:0] ins);
    logic [3:0] op;
    logic [4:0] rd;
    logic       noop;
    logic       br;
    logic       dest;
    logic [1:0] rs;
    op   = ins[INS_W-1 -: 4];
    rd   = ins[TAG_W+27 -: 5];
    noop = 1'b0;
    br   = 1'b0;
    dest = 1'b0;
    rs   = 2'd0;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        rs   = 2'd1;
        dest = 1'b1;
      end
      4'd8: begin
        rs   = 2'd2;
        dest = 1'b1;
      end
      4'd9:    rs = 2'd2;
      4'd10: begin
        rs = 2'd3;
        br = 1'b1;
      end
      default: noop = 1'b1;
    endcase
    return {noop, rs, br, rd, ins[TAG_W+22 -: 5], ins[TAG_W+17 -: 5],
            ins[TAG_W+12 -: 13], dest && (rd != 5'd0), ins[TAG_W-1:0]};
  endfunction

  logic [PREG_W-1:0] fl_q [FL_DEPTH];
  logic [PTR_W-1:0]  cp_q [NUM_TAGS];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              valid_q, valid_d;
  logic [DEC_W-1:0]  dec1_q, dec2_q;
  logic [PREG_W-1:0] preg1_q, preg2_q;
  logic [1:0]        nexec_q;

  logic [DEC_W-1:0]  w_dec1, w_dec2;
  logic              w_has1, w_has2;
  logic [1:0]        w_need;
  logic [PTR_W-1:0]  w_free_cnt;
  logic [PTR_W-1:0]  w_idx2;
  logic [PTR_W-1:0]  w_head_after;
  logic [PTR_W-1:0]  w_tail2;
  logic [PREG_W-1:0] w_p1, w_p2;
  logic [1:0]        w_nexec;
  logic              w_fire;

  assign w_dec1       = decode(instruction_1);
  assign w_dec2       = decode(instruction_2);
  assign w_has1       = w_dec1[HD_BIT];
  assign w_has2       = w_dec2[HD_BIT];
  assign w_need       = {1'b0, w_has1} + {1'b0, w_has2};
  assign w_free_cnt   = tail_q - head_q;
  assign w_idx2       = head_q + PTR_W'(w_has1);
  assign w_head_after = head_q + PTR_W'(w_need);
  assign w_tail2      = tail_q + PTR_W'(free1);
  assign w_p1         = w_has1 ? fl_q[head_q[FL_IDX-1:0]] : '0;
  assign w_p2         = w_has2 ? fl_q[w_idx2[FL_IDX-1:0]] : '0;
  assign w_nexec      = {1'b0, w_dec1[RS_LO +: 2] != 2'd0} + {1'b0, w_dec2[RS_LO +: 2] != 2'd0};

  assign stalled = (valid_q && next_stalled) || (w_free_cnt < PTR_W'(w_need)) || branch_shootdown;
  assign w_fire  = enabled && prev_valid && !clear && !branch_shootdown;

  always_comb begin
    head_d  = head_q;
    valid_d = valid_q;
    tail_d  = tail_q + PTR_W'(free1) + PTR_W'(free2);
    if (clear) begin
      valid_d = 1'b0;
    end else if (branch_shootdown) begin
      head_d  = cp_q[shootdown_branch_tag];
      valid_d = 1'b0;
    end else if (w_fire) begin
      head_d  = w_head_after;
      valid_d = 1'b1;
    end else if (next_enabled) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PREG_W'(ARCH_REGS + i);
      for (int t = 0; t < NUM_TAGS; t++) cp_q[t] <= '0;
      head_q  <= '0;
      tail_q  <= PTR_W'(FL_DEPTH);
      valid_q <= 1'b0;
      dec1_q  <= '0;
      dec2_q  <= '0;
      preg1_q <= '0;
      preg2_q <= '0;
      nexec_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      // Freed entries land behind tail, so they are only visible to allocation next cycle.
      if (free1) fl_q[tail_q[FL_IDX-1:0]]  <= free1_addr;
      if (free2) fl_q[w_tail2[FL_IDX-1:0]] <= free2_addr;
      if (w_fire) begin
        dec1_q  <= w_dec1;
        dec2_q  <= w_dec2;
        preg1_q <= w_p1;
        preg2_q <= w_p2;
        nexec_q <= w_nexec;
        if (w_dec1[BR_BIT]) cp_q[w_dec1[TAG_W-1:0]] <= w_head_after;
        if (w_dec2[BR_BIT]) cp_q[w_dec2[TAG_W-1:0]] <= w_head_after;
      end
    end
  end

  assign valid       = valid_q;
  assign decoded_1   = dec1_q;
  assign decoded_2   = dec2_q;
  assign preg1       = preg1_q;
  assign preg2       = preg2_q;
  assign num_execute = nexec_q;

endmodule
`default_nettype wire

// File: tb/tb_uop_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_uop_decode
// Description : Directed scoreboard bench for uop_decode.
// Revision    : 1.0
// ============================================================================
module tb_uop_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0, prev_valid = 1'b0;
  logic        enabled, next_enabled = 1'b0, next_stalled = 1'b0;
  logic        stalled, valid;
  logic [33:0] instruction_1 = '0, instruction_2 = '0;
  logic [34:0] decoded_1, decoded_2;
  logic [5:0]  preg1, preg2;
  logic [1:0]  num_execute;
  logic        branch_shootdown = 1'b0;
  logic [1:0]  shootdown_branch_tag = '0;
  logic        free1 = 1'b0, free2 = 1'b0;
  logic [5:0]  free1_addr = '0, free2_addr = '0;

  typedef struct packed {
    logic [34:0] d1;
    logic [34:0] d2;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [1:0]  ne;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   mfl[32];
  int   mcp[4];
  int   mhead, mtail;
  bit   mvalid;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Upstream stage enables itself whenever it has work and this stage is not stalled.
  assign enabled = prev_valid && !stalled;

  uop_decode dut (
    .clk(clk), .reset(reset), .clear(clear), .prev_valid(prev_valid),
    .enabled(enabled), .next_enabled(next_enabled), .next_stalled(next_stalled),
    .stalled(stalled), .valid(valid),
    .instruction_1(instruction_1), .instruction_2(instruction_2),
    .decoded_1(decoded_1), .decoded_2(decoded_2),
    .preg1(preg1), .preg2(preg2), .num_execute(num_execute),
    .branch_shootdown(branch_shootdown), .shootdown_branch_tag(shootdown_branch_tag),
    .free1(free1), .free2(free2), .free1_addr(free1_addr), .free2_addr(free2_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int imm, input int tag);
    return {4'(op), 5'(rd), 5'(rs1), 5'(rs2), 13'(imm), 2'(tag)};
  endfunction

  function automatic logic [34:0] dec(input logic [33:0] ins);
    logic [3:0] op;
    logic [4:0] rd;
    logic       noop, br, hd;
    logic [1:0] rs;
    op = ins[33:30];
    rd = ins[29:25];
    noop = 1'b0; br = 1'b0; hd = 1'b0; rs = 2'd0;
    if (op >= 4'd1 && op <= 4'd7) begin rs = 2'd1; hd = 1'b1; end
    else if (op == 4'd8) begin rs = 2'd2; hd = 1'b1; end
    else if (op == 4'd9) rs = 2'd2;
    else if (op == 4'd10) begin rs = 2'd3; br = 1'b1; end
    else noop = 1'b1;
    if (rd == 5'd0) hd = 1'b0;
    return {noop, rs, br, rd, ins[24:20], ins[19:15], ins[14:2], hd, ins[1:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mfl[i] = 32 + i;
    for (int t = 0; t < 4; t++) mcp[t] = 0;
    mhead = 0;
    mtail = 32;
    mvalid = 0;
    sbq.delete();
    last = '0;
  endtask

  task automatic pair(input logic [33:0] a, input logic [33:0] b);
    instruction_1 = a;
    instruction_2 = b;
    prev_valid = 1'b1;
  endtask

  // One clock: predict stall and the registered result, advance the model, compare after the edge.
  task automatic tick();
    exp_t        e;
    logic [34:0] d1, d2;
    int          need;
    bit          exp_stall;
    #1;
    d1 = dec(instruction_1);
    d2 = dec(instruction_2);
    need = int'(d1[2]) + int'(d2[2]);
    exp_stall = (mvalid && next_stalled) || ((mtail - mhead) < need) || branch_shootdown;
    if (reset) begin
      model_reset();
    end else begin
      chk("stalled", {63'd0, stalled}, {63'd0, exp_stall});
      if (clear) mvalid = 0;
      else if (branch_shootdown) begin
        mhead = mcp[shootdown_branch_tag];
        mvalid = 0;
      end else if (prev_valid && !exp_stall) begin
        e.d1 = d1;
        e.d2 = d2;
        e.p1 = d1[2] ? 6'(mfl[mhead % 32]) : 6'd0;
        e.p2 = d2[2] ? 6'(mfl[(mhead + int'(d1[2])) % 32]) : 6'd0;
        e.ne = 2'(int'(d1[33:32] != 2'd0) + int'(d2[33:32] != 2'd0));
        mhead += need;
        if (d1[31]) mcp[d1[1:0]] = mhead % 64;
        if (d2[31]) mcp[d2[1:0]] = mhead % 64;
        mvalid = 1;
        sbq.push_back(e);
      end else if (next_enabled) mvalid = 0;
      if (free1) begin mfl[mtail % 32] = int'(free1_addr); mtail++; end
      if (free2) begin mfl[mtail % 32] = int'(free2_addr); mtail++; end
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) last = sbq.pop_front();
    chk("decoded_1", {29'd0, decoded_1}, {29'd0, last.d1});
    chk("decoded_2", {29'd0, decoded_2}, {29'd0, last.d2});
    chk("preg1", {58'd0, preg1}, {58'd0, last.p1});
    chk("preg2", {58'd0, preg2}, {58'd0, last.p2});
    chk("num_execute", {62'd0, num_execute}, {62'd0, last.ne});
    chk("valid", {63'd0, valid}, {63'd0, mvalid});
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_preg1", {58'd0, preg1}, 64'd0);
    chk("rst_dec1", {29'd0, decoded_1}, 64'd0);

    // First ALU pair takes pregs 32 and 33
    pair(mk(1, 1, 3, 4, 100, 0), mk(2, 2, 5, 6, 7, 0));
    tick();
    chk("alu_preg1", {58'd0, preg1}, 64'd32);
    chk("alu_preg2", {58'd0, preg2}, 64'd33);
    chk("alu_nexec", {62'd0, num_execute}, 64'd2);
    chk("alu_valid", {63'd0, valid}, 64'd1);

    pair(mk(0, 3, 1, 1, 1, 0), mk(9, 7, 2, 3, 4, 0));
    tick();
    chk("nopst_preg1", {58'd0, preg1}, 64'd0);
    chk("nopst_preg2", {58'd0, preg2}, 64'd0);
    chk("nopst_nexec", {62'd0, num_execute}, 64'd1);

    // Opcode 12 decodes as a no-op; a load to r0 needs no preg
    pair(mk(12, 3, 1, 2, 3, 2), mk(8, 0, 4, 5, 6, 3));
    tick();
    pair(mk(3, 4, 1, 2, 9, 0), mk(8, 9, 2, 3, 8191, 0));
    tick();
    chk("head_kept", {58'd0, preg1}, 64'd34);

    next_stalled = 1'b1;
    tick();
    tick();
    chk("hold_preg2", {58'd0, preg2}, 64'd35);
    next_stalled = 1'b0;
    prev_valid = 1'b0;
    next_enabled = 1'b1;
    tick();
    chk("drain_valid", {63'd0, valid}, 64'd0);
    next_enabled = 1'b0;

    // Branch tag 1 at head 4, three allocations, then shoot it down
    pair(mk(10, 0, 1, 2, 5, 1), mk(0, 0, 0, 0, 0, 0));
    tick();
    pair(mk(1, 5, 1, 2, 0, 0), mk(1, 6, 1, 2, 0, 0));
    tick();
    pair(mk(1, 7, 1, 2, 0, 0), mk(0, 0, 0, 0, 0, 0));
    tick();
    prev_valid = 1'b0;
    branch_shootdown = 1'b1;
    shootdown_branch_tag = 2'd1;
    tick();
    chk("shoot_valid", {63'd0, valid}, 64'd0);
    branch_shootdown = 1'b0;
    pair(mk(2, 8, 1, 2, 0, 0), mk(2, 9, 1, 2, 0, 0));
    tick();
    chk("shoot_realloc", {58'd0, preg1}, 64'd36);

    // Clear beats enable; the simultaneous free still lands
    clear = 1'b1;
    free1 = 1'b1;
    free1_addr = 6'd7;
    tick();
    chk("clear_valid", {63'd0, valid}, 64'd0);
    clear = 1'b0;
    free1 = 1'b0;
    tick();
    chk("clear_head", {58'd0, preg1}, 64'd38);

    for (int i = 0; i < 40 && (mtail - mhead) >= 2; i++) tick();
    if ((mtail - mhead) == 1) begin
      pair(mk(4, 10, 1, 2, 0, 0), mk(0, 0, 0, 0, 0, 0));
      tick();
    end
    chk("empty_count", 64'(mtail - mhead), 64'd0);

    pair(mk(5, 11, 1, 2, 0, 0), mk(6, 12, 1, 2, 0, 0));
    free1 = 1'b1;
    free1_addr = 6'd5;
    #1 chk("empty_stall", {63'd0, stalled}, 64'd1);
    tick();
    free1 = 1'b0;
    free2 = 1'b1;
    free2_addr = 6'd6;
    #1 chk("one_free_stall", {63'd0, stalled}, 64'd1);
    tick();
    free2 = 1'b0;
    #1 chk("two_free_go", {63'd0, stalled}, 64'd0);
    tick();
    chk("refill_preg1", {58'd0, preg1}, 64'd5);
    chk("refill_preg2", {58'd0, preg2}, 64'd6);

    // Reset overrides everything in flight
    reset = 1'b1;
    clear = 1'b1;
    free1 = 1'b1;
    free1_addr = 6'd9;
    tick();
    reset = 1'b0;
    clear = 1'b0;
    free1 = 1'b0;
    chk("rst2_valid", {63'd0, valid}, 64'd0);
    pair(mk(7, 1, 1, 2, 0, 0), mk(7, 2, 1, 2, 0, 0));
    tick();
    chk("rst2_preg1", {58'd0, preg1}, 64'd32);
    prev_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uop_decode.md
UOP_DECODE -- requirements
Module: uop_decode

Interface
REQ-001 Parameters: NUM_PREGS = 64 (physical registers); MAX_PREDICT_DEPTH_BITS = 2 (4 branch tags); ARCH_REGS = 32.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clear  in  1  pipeline flush.
REQ-005 prev_valid, enabled, next_enabled, next_stalled  in  1 each  pipeline handshake (enabled = prev_valid && !stalled; next_enabled = downstream stage enabled).
REQ-006 stalled, valid  out  1 each  stage stalled / output register holds valid decode.
REQ-007 instruction_1, instruction_2  in  32+2 each  {instruction[31:0], branch_tag[1:0]}; instruction_1 is older.
REQ-008 decoded_1, decoded_2  out  struct each  {is_noop, rs_station[1:0], is_branch, rd[4:0], rs1[4:0], rs2[4:0], imm[12:0], has_dest, branch_tag[1:0]}.
REQ-009 preg1, preg2  out  6 each  physical destination register allocated for decoded_1 / decoded_2.
REQ-010 num_execute  out  2  count of decoded pair entries with rs_station != 0.
REQ-011 branch_shootdown  in  1; shootdown_branch_tag  in  2  mispredicted-branch freelist restore.
REQ-012 free1, free2  in  1 each; free1_addr, free2_addr  in  6 each  commit-stage register releases.

Function
REQ-013 Instruction fields: opcode = [31:28], rd = [27:23], rs1 = [22:18], rs2 = [17:13], imm = [12:0].
REQ-014 Opcode 0 -> is_noop=1, rs_station=0; 1-7 (ALU) -> rs_station=1, has_dest; 8 (load) -> rs_station=2, has_dest; 9 (store) -> rs_station=2, no dest; 10 (branch) -> rs_station=3, is_branch=1, no dest; 11-15 -> treated as opcode 0.
REQ-015 has_dest is forced 0 when rd = 0; an entry needs a preg iff has_dest.
REQ-016 Freelist: 32-entry circular FIFO; 6-bit head/tail pointers (5-bit index plus wrap bit); free count = tail - head.
REQ-017 Allocation order: instruction_1 takes entry head, instruction_2 takes the next entry; an entry without a dest consumes nothing and its preg output is 0.
REQ-018 stalled (combinational) = (valid && next_stalled) || (free count < number of pregs needed by the pair) || branch_shootdown.
REQ-019 When enabled: latch decoded_1/2, preg1/2 and num_execute; advance head by the number of pregs allocated; valid <= 1.
REQ-020 When not enabled and next_enabled: valid <= 0. Otherwise all outputs hold.
REQ-021 Checkpoint: for each decoded branch, store the head value after all allocations of the pair into checkpoint[branch_tag]; if both entries are branches, slot 2 is written last.
REQ-022 branch_shootdown: head <= checkpoint[shootdown_branch_tag]; valid <= 0; no allocation that cycle.
REQ-023 Frees: free1 pushes free1_addr at tail, then free2 pushes free2_addr; the tail advances by 0-2. Frees are applied every cycle, including stall, clear and shootdown cycles.
REQ-024 A freed register becomes allocatable in the following cycle, not the same cycle.
REQ-025 clear: valid <= 0; no allocation that cycle; the freelist is otherwise unchanged.
REQ-026 Priority: reset > clear > branch_shootdown > enabled > next_enabled.

Reset
REQ-027 Reset: valid = 0; decoded outputs, preg1/2 and num_execute = 0; freelist entries i = 32+i (pregs 32-63); head = 0; tail = 32 (full); checkpoints = 0.
REQ-028 Reset during any operation overrides clear, shootdown, allocation and frees in the same cycle.

Verification
REQ-029 Verification: after reset, pair ALU rd=1 / ALU rd=2 enabled -> next cycle valid=1, preg1=32, preg2=33, num_execute=2.
REQ-030 Verification: pair NOP / store -> preg1=0, preg2=0, num_execute=1, head unchanged.
REQ-031 Verification: allocate all 32 free pregs, then present a pair needing 2 pregs -> stalled=1; assert free1 with free1_addr=5 -> still stalled next cycle (needs 2); add free2 with free2_addr=6 -> the pair then allocates 5 and 6.
REQ-032 Verification: branch with tag 1 decoded at head=4, then 3 more allocations, then branch_shootdown with tag 1 -> valid=0; next allocation returns the register at freelist index 4.
REQ-033 Verification: valid=1 with next_stalled=1 -> stalled=1 and outputs hold; next_enabled=1 with prev_valid=0 -> valid drops to 0.
REQ-034 Verification: clear coinciding with enabled -> valid=0 and head unchanged; a simultaneous free still increments the free count by 1.
